// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, frame constants, command bytes and parity helper.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE, DONE} ps2_state_e;
    localparam int PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and completion status for the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic tx_valid, tx_ready, done, ack_err, busy;
    modport master (output tx_data, tx_valid, input tx_ready, done, ack_err, busy);
    modport slave (input tx_data, tx_valid, output tx_ready, done, ack_err, busy);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for PS/2 clock/data plus clock falling-edge pulse.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);
    logic clk_m, data_m, clk_s_prev;
    // Idle PS/2 lines are high, so reset the chain high to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {clk_m, clk_s, clk_s_prev, data_m, data_s} <= '1;
        else begin
            {clk_s_prev, clk_s, clk_m} <= {clk_s, clk_m, ps2_clk_in};
            {data_s, data_m} <= {data_m, ps2_data_in};
        end
    assign clk_fall = clk_s_prev & ~clk_s;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with odd parity and ACK check.
// Optional SHIFT/ACK timeout is built in when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    ps2_state_e state;
    logic [31:0] cnt;
    logic [3:0] n;
    logic [9:0] frame;
    logic nack, clk_s, data_s, clk_fall;
    ps2_line_sync u_sync (
        .clk(clk),
        .reset_n(reset_n),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_s(clk_s),
        .data_s(data_s),
        .clk_fall(clk_fall)
    );
    assign bus.busy = ~bus.tx_ready;
    // frame holds {stop, parity, data}; edge n+1 drives ~frame[n] onto the data enable.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            n <= '0;
            frame <= '0;
            nack <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            bus.tx_ready <= 1'b1;
            bus.done <= 1'b0;
            bus.ack_err <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.tx_valid) begin
                    frame <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                    bus.tx_ready <= 1'b0;
                    bus.ack_err <= 1'b0;
                    ps2_clk_oe <= 1'b1;
                    ps2_data_oe <= INHIBIT_CYCLES == 1;
                    cnt <= '0;
                    state <= INHIBIT;
                end
                INHIBIT: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == 32'(INHIBIT_CYCLES - 2)) ps2_data_oe <= 1'b1;
                    if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        cnt <= '0;
                        n <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: if (clk_fall) begin
                    n <= n + 4'd1;
                    ps2_data_oe <= ~frame[n];
                    if (n == 4'(PS2_FRAME_BITS - 2)) state <= ACK;
                end
                ACK: if (clk_fall) begin
                    nack <= data_s;
                    state <= WAIT_IDLE;
                end
                WAIT_IDLE: if (clk_s && data_s) begin
                    bus.done <= 1'b1;
                    bus.ack_err <= nack;
                    state <= DONE;
                end
                DONE: begin
                    bus.tx_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
            if (state == SHIFT || state == ACK) begin
                cnt <= cnt + 32'd1;
                if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    ps2_clk_oe <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    bus.ack_err <= 1'b1;
                    bus.done <= 1'b1;
                    state <= DONE;
                end
            end
`endif
        end
`ifndef PS2_HOST_TX_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: accepts one command byte (e.g. 0xED set-LEDs, 0xFF reset) and sends it to the keyboard by the PS/2 host-request procedure. Sends the byte with odd parity and checks the device ACK. Sits beside the keyboard receive buffer on the same PS/2 clock/data pins. Drives the lines only through open-drain enables. The top level ties each pin as `oe ? 1'b0 : 1'bz`.

## Interface
- `INHIBIT_CYCLES`, 5000: system clocks the PS/2 clock is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum system clocks from clock release to ACK (15 ms at 50 MHz).
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE. A transfer is accepted when `tx_valid && tx_ready`.
- `ps2_clk_in`, `ps2_data_in`  in  1 each  raw pin levels (asynchronous).
- `ps2_clk_oe`, `ps2_data_oe`  out  1 each  1 = pull the line low.
- `done`  out  1  one-cycle pulse when a transfer ends, for any reason.
- `ack_err`  out  1  valid with `done`. 1 = no ACK or timeout.
- `busy`  out  1  equals `~tx_ready`.

## Operation
- The inputs pass through a two-flop synchronizer. The PS/2 clock falling-edge pulse is `clk_s_prev & ~clk_s`.
- States and transitions:
  - IDLE: on accept, latch `tx_data` and parity `~^tx_data` → INHIBIT.
  - INHIBIT: `ps2_clk_oe=1`. The counter runs 0..INHIBIT_CYCLES-1. `ps2_data_oe=1` in the final count cycle (start bit). At terminal count → SHIFT.
  - SHIFT: `ps2_clk_oe=0` and `ps2_data_oe` held at 1 (start bit). The bit counter n starts at 0 and increments on each PS/2 falling edge:
    - edges 1–8 drive data bit n-1, LSB first, with `ps2_data_oe = ~bit`;
    - edge 9 drives parity;
    - edge 10 drives stop (`ps2_data_oe=0`) → ACK.
  - ACK: on the next falling edge, sample `data_s`. 0 = ACK OK, 1 = `ack_err` → WAIT_IDLE.
  - WAIT_IDLE: wait until `clk_s` and `data_s` are both 1 → DONE.
  - DONE: one cycle with `done=1` → IDLE.
- A frame is 11 PS/2 clocks: start, 8 data bits, parity, stop. The ACK occupies the 11th.
- A `tx_valid` that arrives while busy is ignored. It is not queued.
- `tx_data` is captured at accept. Later changes have no effect on the frame.

## Timing
- Reset values: `tx_ready=1`, `busy=0`, `ps2_clk_oe=0`, `ps2_data_oe=0`, `done=0`, `ack_err=0`, state IDLE, all counters 0.
- Accept at cycle T: `ps2_clk_oe=1` from T+1.
- `ps2_data_oe=1` from T+INHIBIT_CYCLES.
- `ps2_clk_oe=0` from T+INHIBIT_CYCLES+1.
- Data updates 3 system cycles after each pin falling edge: 2 sync stages plus the registered output. This is well inside the device's ≥5 µs clock-low phase.
- `done` and `ack_err` are asserted in the same cycle. `ack_err` holds until the next accept.
- Reset mid-frame: both OE outputs drop asynchronously, which releases the lines. The block resumes in IDLE after `reset_n` rises. No `done` pulse is issued for the aborted frame.
- Falling edges seen during INHIBIT or WAIT_IDLE are ignored.

## Configuration
- `PS2_HOST_TX_TIMEOUT_EN` defined: a timeout counter starts at SHIFT entry and counts up while in SHIFT/ACK. When it reaches TIMEOUT_CYCLES-1:
  - release both lines;
  - set `ack_err=1`;
  - go to DONE (skip WAIT_IDLE).
- Not defined: there is no counter, and the block waits indefinitely for device clocks. Only `reset_n` recovers a hung transfer.

## Structure
- Package `ps2_pkg`:
  - the state enum (IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE, DONE);
  - `PS2_FRAME_BITS=11`;
  - command constants `PS2_CMD_SET_LEDS=8'hED` and `PS2_CMD_RESET=8'hFF`;
  - an odd-parity function.
- Sub-module `ps2_line_sync`: two-flop sync of both lines, plus the clock falling-edge pulse. It is reusable by the receive path.

## Test plan
- Send 0xED with INHIBIT_CYCLES=10; the device model ACKs. Required:
  - clock low for exactly 10 cycles;
  - device samples 0, 1,0,1,1,0,1,1,1, 1, 1 (start, LSB-first data, parity=1, stop);
  - `done=1`, `ack_err=0`.
- Send 0x01 → device sees parity bit 0. ACK OK.
- Device leaves data high on the 11th clock → `done` with `ack_err=1`, and both OE outputs are 0.
- With the macro defined and TIMEOUT_CYCLES=200, the device never clocks. Required:
  - `done` and `ack_err=1` exactly 200 cycles after SHIFT entry;
  - lines released.
- Pulse `tx_valid` with 0x55 mid-frame → `tx_ready=0`, and the frame still carries the original byte. No second frame follows.
- Assert `reset_n=0` during data bit 4 → both OE outputs are 0 in the same cycle, and `tx_ready=1` the cycle after release. No `done` pulse.
